// File: rtl/uart_pkg.sv
// Shared UART definitions: default geometry and the receive-buffer capture states.
package uart_pkg;

    localparam int UART_DEPTH  = 8;
    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } rxbuf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO with explicit occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_DEPTH,
    parameter int DATA_W = UART_DATA_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// Drains bytes from the UART receiver into a FWFT FIFO, acknowledging each one
// so the serial side never stalls; tracks a sticky overrun for discarded bytes.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_DEPTH,
    parameter int DATA_W = UART_DATA_W,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rda,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rd_rx,
    input  logic              cpu_rd,
    output logic [DATA_W-1:0] cpu_data,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count,
    output logic              overrun,
    input  logic              clr_ovr,
    output logic [1:0]        dbg_state
);

    rxbuf_state_t state_q, state_d;
    logic         rd_rx_q, rd_rx_d;
    logic         overrun_q, overrun_d;
    logic         push_req;
    logic         discard;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_req),
        .push_data_i (rx_data),
        .pop_i       (cpu_rd),
        .head_o      (cpu_data),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    // WAIT holds off until rda drops, so each rda assertion yields exactly one push.
    always_comb begin
        state_d   = state_q;
        rd_rx_d   = 1'b0;
        push_req  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rda) begin
                    push_req = 1'b1;
                    rd_rx_d  = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK:     state_d = WAIT;
            WAIT: begin
                if (!rda) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A full FIFO can still take the byte if the bus pops in the same cycle.
        discard   = push_req && full && !cpu_rd;
        overrun_d = discard || (overrun_q && !clr_ovr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_rx_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_rx_q   <= rd_rx_d;
            overrun_q <= overrun_d;
        end
    end

    assign rd_rx     = rd_rx_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: scenario tasks with a byte scoreboard.
module tb_uart_rx_buffer;
    import uart_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       rda;
    logic [7:0] rx_data;
    logic       rd_rx;
    logic       cpu_rd;
    logic [7:0] cpu_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       overrun;
    logic       clr_ovr;
    logic [1:0] dbg_state;

    logic [7:0] exp_q[$];
    int         chk_n;
    int         pass_n;

    uart_rx_buffer #(.DEPTH(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rda       (rda),
        .rx_data   (rx_data),
        .rd_rx     (rd_rx),
        .cpu_rd    (cpu_rd),
        .cpu_data  (cpu_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: one receiver byte; rda held for one edge; returns rd_rx pulse count.
    task automatic send_byte(input logic [7:0] b, output int pulses);
        @(negedge clk);
        rda     = 1'b1;
        rx_data = b;
        pulses  = 0;
        @(negedge clk);
        if (rd_rx) pulses++;
        rda = 1'b0;
        @(negedge clk);
        if (rd_rx) pulses++;
        @(negedge clk);
        if (rd_rx) pulses++;
    endtask

    // Driver: one bus pop; returns the head seen before the pop edge.
    task automatic pop_one(output logic [7:0] d);
        @(negedge clk);
        d      = cpu_data;
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        int p;
        for (int i = 0; i < 8; i++) begin
            send_byte(base + 8'(i), p);
            exp_q.push_back(base + 8'(i));
        end
    endtask

    task automatic drain(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_one(d);
            chk_n++;
            if (d !== e) $display("FAIL %s_data got %02h exp %02h", tag, d, e);
            else pass_n++;
        end
        chk_n++;
        if (empty !== 1'b1) $display("FAIL %s_empty got %0b exp 1", tag, empty);
        else pass_n++;
    endtask

    task automatic test_reset();
        chk_n++;
        if ({empty, full, count, rd_rx, overrun} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0})
            $display("FAIL reset_status got e%0b f%0b c%0d r%0b o%0b exp e1 f0 c0 r0 o0",
                     empty, full, count, rd_rx, overrun);
        else pass_n++;
        chk_n++;
        if (cpu_data !== 8'h00) $display("FAIL reset_data got %02h exp 00", cpu_data);
        else pass_n++;
        chk_n++;
        if (dbg_state !== 2'(IDLE)) $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE);
        else pass_n++;
    endtask

    task automatic test_single_byte();
        int p;
        send_byte(8'hA5, p);
        exp_q.push_back(8'hA5);
        chk_n++;
        if (p !== 1) $display("FAIL single_pulses got %0d exp 1", p);
        else pass_n++;
        chk_n++;
        if (cpu_data !== 8'hA5) $display("FAIL single_head got %02h exp a5", cpu_data);
        else pass_n++;
        chk_n++;
        if (count !== 4'd1) $display("FAIL single_count got %0d exp 1", count);
        else pass_n++;
        drain("single");
        chk_n++;
        if (cpu_data !== 8'h00) $display("FAIL single_empty_data got %02h exp 00", cpu_data);
        else pass_n++;
    endtask

    task automatic test_fill_overrun();
        int p;
        fill(8'h00);
        chk_n++;
        if ({full, count, overrun} !== {1'b1, 4'd8, 1'b0})
            $display("FAIL fill_status got f%0b c%0d o%0b exp f1 c8 o0", full, count, overrun);
        else pass_n++;
        send_byte(8'hFF, p);
        chk_n++;
        if (p !== 1) $display("FAIL ovr_pulses got %0d exp 1", p);
        else pass_n++;
        chk_n++;
        if ({overrun, count} !== {1'b1, 4'd8})
            $display("FAIL ovr_status got o%0b c%0d exp o1 c8", overrun, count);
        else pass_n++;
        drain("fill");
        chk_n++;
        if (overrun !== 1'b1) $display("FAIL ovr_sticky got %0b exp 1", overrun);
        else pass_n++;
        @(negedge clk) clr_ovr = 1'b1;
        @(negedge clk) clr_ovr = 1'b0;
        chk_n++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear got %0b exp 0", overrun);
        else pass_n++;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] d;
        logic [7:0] e;
        fill(8'h10);
        @(negedge clk);
        rda     = 1'b1;
        rx_data = 8'h5A;
        cpu_rd  = 1'b1;
        d       = cpu_data;
        e       = exp_q.pop_front();
        exp_q.push_back(8'h5A);
        chk_n++;
        if (d !== e) $display("FAIL ppf_head got %02h exp %02h", d, e);
        else pass_n++;
        @(negedge clk);
        rda    = 1'b0;
        cpu_rd = 1'b0;
        chk_n++;
        if ({rd_rx, overrun, full, count} !== {1'b1, 1'b0, 1'b1, 4'd8})
            $display("FAIL ppf_status got r%0b o%0b f%0b c%0d exp r1 o0 f1 c8",
                     rd_rx, overrun, full, count);
        else pass_n++;
        repeat (2) @(negedge clk);
        chk_n++;
        if (exp_q[7] !== 8'h5A) $display("FAIL ppf_last got %02h exp 5a", exp_q[7]);
        else pass_n++;
        drain("ppf");
    endtask

    task automatic test_empty_read_held_rda();
        int p;
        @(negedge clk) cpu_rd = 1'b1;
        @(negedge clk) cpu_rd = 1'b0;
        chk_n++;
        if ({empty, count, cpu_data} !== {1'b1, 4'd0, 8'h00})
            $display("FAIL eread_status got e%0b c%0d d%02h exp e1 c0 d00", empty, count, cpu_data);
        else pass_n++;
        send_byte(8'h3C, p);
        exp_q.push_back(8'h3C);
        chk_n++;
        if (cpu_data !== 8'h3C) $display("FAIL eread_head got %02h exp 3c", cpu_data);
        else pass_n++;
        @(negedge clk);
        rda     = 1'b1;
        rx_data = 8'h77;
        p       = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_rx) p++;
        end
        rda = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rd_rx) p++;
        end
        exp_q.push_back(8'h77);
        chk_n++;
        if (p !== 1) $display("FAIL held_pulses got %0d exp 1", p);
        else pass_n++;
        chk_n++;
        if (count !== 4'd2) $display("FAIL held_count got %0d exp 2", count);
        else pass_n++;
        drain("held");
    endtask

    task automatic test_overrun_collision();
        fill(8'h20);
        @(negedge clk);
        rda     = 1'b1;
        rx_data = 8'hEE;
        clr_ovr = 1'b1;
        @(negedge clk);
        rda     = 1'b0;
        clr_ovr = 1'b0;
        chk_n++;
        if ({overrun, count} !== {1'b1, 4'd8})
            $display("FAIL coll_status got o%0b c%0d exp o1 c8", overrun, count);
        else pass_n++;
        repeat (2) @(negedge clk);
        @(negedge clk) clr_ovr = 1'b1;
        @(negedge clk) clr_ovr = 1'b0;
        chk_n++;
        if (overrun !== 1'b0) $display("FAIL coll_clear got %0b exp 0", overrun);
        else pass_n++;
        drain("coll");
    endtask

    task automatic test_reset_mid();
        int p;
        logic [7:0] d;
        fill(8'h40);
        send_byte(8'h99, p);
        @(negedge clk);
        rda     = 1'b1;
        rx_data = 8'h22;
        @(negedge clk);
        rst_n   = 1'b0;
        rx_data = 8'h33;
        #1;
        chk_n++;
        if ({rd_rx, empty, full, count, overrun} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0})
            $display("FAIL rstmid_status got r%0b e%0b f%0b c%0d o%0b exp r0 e1 f0 c0 o0",
                     rd_rx, empty, full, count, overrun);
        else pass_n++;
        chk_n++;
        if ({cpu_data, dbg_state} !== {8'h00, 2'(IDLE)})
            $display("FAIL rstmid_data got %02h/%0d exp 00/0", cpu_data, dbg_state);
        else pass_n++;
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        chk_n++;
        if (count !== 4'd0) $display("FAIL rstmid_release_count got %0d exp 0", count);
        else pass_n++;
        @(negedge clk);
        rda = 1'b0;
        exp_q.push_back(8'h33);
        chk_n++;
        if ({rd_rx, count, cpu_data} !== {1'b1, 4'd1, 8'h33})
            $display("FAIL rstmid_recapture got r%0b c%0d d%02h exp r1 c1 d33", rd_rx, count, cpu_data);
        else pass_n++;
        repeat (2) @(negedge clk);
        drain("rstmid");
        d = 8'h00;
        pop_one(d);
        chk_n++;
        if ({count, empty} !== {4'd0, 1'b1})
            $display("FAIL final_idle got c%0d e%0b exp c0 e1", count, empty);
        else pass_n++;
    endtask

    initial begin
        chk_n   = 0;
        pass_n  = 0;
        rst_n   = 1'b0;
        rda     = 1'b0;
        rx_data = 8'($urandom_range(0, 255));
        cpu_rd  = 1'b0;
        clr_ovr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_fill_overrun();
        test_push_pop_full();
        test_empty_read_held_rda();
        test_overrun_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side buffer that sits directly downstream of the UART receiver. Whenever the receiver flags a byte ready, it drains the byte into a DEPTH-entry FIFO and pulses the receiver's read acknowledge, so the serial line is never back-pressured by a slow consumer. It presents the bytes to the processor-side bus as a first-word-fall-through queue, with full/empty/count status and a sticky overrun flag.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- DATA_W, 8, byte width; matches receiver data width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rda  in  1  receiver data-available flag
- rx_data  in  DATA_W  receiver byte, valid while rda=1
- rd_rx  out  1  one-cycle acknowledge to receiver; registered
- cpu_rd  in  1  pop request from bus side
- cpu_data  out  DATA_W  head of FIFO; 0 when empty
- empty  out  1  FIFO holds no bytes
- full  out  1  FIFO holds DEPTH bytes
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- overrun  out  1  sticky: a received byte was discarded
- clr_ovr  in  1  clears overrun

## Operation
- Capture FSM states: IDLE, ACK, WAIT.
- IDLE: if rda=1 → push rx_data (or discard, see below), set rd_rx, go ACK. Otherwise stay.
- ACK: rd_rx=1 for exactly this one cycle; go WAIT unconditionally.
- WAIT: stay while rda=1; go IDLE when rda=0. This guarantees one push per rda assertion regardless of receiver clear latency.
- Push when full: byte discarded, rd_rx still pulsed (the receiver must be freed), overrun set. Exception: if cpu_rd=1 in the same cycle, the pop frees a slot and the push is accepted with no overrun.
- Pop: cpu_rd=1 and empty=0 removes the head. cpu_rd while empty is ignored; no pointer or count change.
- Simultaneous push and pop: both take effect and count is unchanged, including at full and at count=1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked explicitly, with full=(count==DEPTH) and empty=(count==0).
- overrun: set on a discard and cleared by clr_ovr. If a set and a clear land in the same cycle, set wins.

## Timing
- Reset (async assert, sync-style deassert by system): state=IDLE, pointers=0, count=0, empty=1, full=0, rd_rx=0, overrun=0, cpu_data=0. Memory contents are not reset.
- Capture latency: rda sampled high at edge E → byte visible on cpu_data and empty=0 after E; rd_rx high for the cycle after E; rda is expected low by E+2.
- Minimum spacing between accepted bytes: 3 cycles. The receiver's 16x byte period exceeds this by orders of magnitude.
- Pop latency: cpu_rd at edge E → next head on cpu_data and count decremented after E.
- Status outputs (empty, full, count, overrun) are registered or derived from registered count only; no combinational path from cpu_rd or rda.
- Reset asserted mid-handshake: FSM returns to IDLE and any buffered bytes are lost. If rda is still high after reset, it is captured again as a new byte.

## Structure
- Shared package uart_pkg holds:
  - rxbuf_state_t enum (IDLE, ACK, WAIT)
  - default DEPTH and DATA_W constants, shared with the receiver and transmitter
- One natural sub-module: sync_fifo, a generic DEPTH×DATA_W FWFT FIFO with push/pop/count/full/empty.
  - uart_rx_buffer wraps it with the capture FSM and the overrun logic.
  - sync_fifo is reusable for the transmit side.

## Test plan
- Reset check: assert rst_n=0 mid-operation → all outputs at reset values within the same cycle, and count=0 after release.
- Single byte: rda=1 with rx_data=0xA5 → rd_rx pulses exactly 1 cycle, cpu_data=0xA5, count=1; cpu_rd → empty=1, cpu_data=0.
- Fill and overrun: push 0x00..0x07 → full=1, count=8; push a 9th byte 0xFF → rd_rx still pulses, overrun=1, count stays 8; drain reads 0x00..0x07 in order (wrap exercised).
- Push and pop at full: full FIFO, rda with 0x5A coincident with cpu_rd → no overrun, count=8, 0x5A read last.
- Empty read and held rda: cpu_rd on empty → no change. rda held high 10 cycles → exactly one push and one rd_rx pulse.
- Overrun collision: clr_ovr in the same cycle as a discard → overrun=1; next clr_ovr alone → overrun=0.
